notification_arbiter: RTL and testbench

NOTIFICATION_ARBITER -- requirements
Module: notification_arbiter

---
 rtl/notification_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_notification_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/notification_arbiter.sv
// Round-robin funnel of per-port Trapper requests onto one monitor-bypass channel, with
// availability responses routed back by port tag. Define NOTIF_ARB_STATS_EN for grant counters.
module notification_arbiter #(
  parameter int NUM_PORTS          = 4,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int CHANNEL_ADDR_WIDTH = 34,
  parameter int BEATS              = 4,
  parameter int C_BRAM_DATA_WIDTH  = 512,
  parameter int MAX_OUTSTANDING    = 8
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_PORTS*CHANNEL_ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_PORTS*C_S_AXI_ID_WIDTH-1:0]         req_id,
  input  logic [NUM_PORTS*$clog2(BEATS)-1:0]            req_offset,
  input  logic [NUM_PORTS-1:0]                          req_valid,
  output logic [NUM_PORTS-1:0]                          port_ready,
  output logic [CHANNEL_ADDR_WIDTH-1:0]                 m_req_addr,
  output logic [$clog2(BEATS)-1:0]                      m_req_offset,
  output logic [C_S_AXI_ID_WIDTH+$clog2(NUM_PORTS)-1:0] m_req_id,
  output logic                                          m_req_valid,
  input  logic                                          m_req_ready,
  input  logic [CHANNEL_ADDR_WIDTH-1:0]                 avail_addr,
  input  logic [$clog2(BEATS)-1:0]                      avail_offset,
  input  logic [C_S_AXI_ID_WIDTH+$clog2(NUM_PORTS)-1:0] avail_id,
  input  logic [C_BRAM_DATA_WIDTH-1:0]                  avail_data,
  input  logic                                          avail_valid,
  output logic [CHANNEL_ADDR_WIDTH-1:0]                 out_avail_addr,
  output logic [$clog2(BEATS)-1:0]                      out_avail_offset,
  output logic [C_S_AXI_ID_WIDTH-1:0]                   out_avail_id,
  output logic [C_BRAM_DATA_WIDTH-1:0]                  out_avail_data,
  output logic [NUM_PORTS-1:0]                          out_avail_valid,
  output logic                                          err_underflow,
  output logic [NUM_PORTS*32-1:0]                       stat_grants
);
  localparam int AW = CHANNEL_ADDR_WIDTH;
  localparam int IW = C_S_AXI_ID_WIDTH;
  localparam int OW = $clog2(BEATS);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = IW + PW;
  localparam int DW = C_BRAM_DATA_WIDTH;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
  localparam logic [PW:0]   NP_EXT    = (PW+1)'(NUM_PORTS);

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;

  logic [NUM_PORTS-1:0] hold_valid_q;
  logic [AW-1:0]        hold_addr_q [NUM_PORTS];
  logic [IW-1:0]        hold_id_q   [NUM_PORTS];
  logic [OW-1:0]        hold_off_q  [NUM_PORTS];
  logic [CW-1:0]        outstanding_q [NUM_PORTS];

  logic [PW-1:0] rr_ptr_q, grant_q, win_idx, cand;
  logic [PW:0]   cand_sum;
  logic          win_found, load_offer, done_offer;

  logic [AW-1:0] m_addr_q;
  logic [OW-1:0] m_off_q;
  logic [TW-1:0] m_id_q;
  logic          m_valid_q;

  logic [AW-1:0]        av_addr_q;
  logic [OW-1:0]        av_off_q;
  logic [IW-1:0]        av_id_q;
  logic [DW-1:0]        av_data_q;
  logic [NUM_PORTS-1:0] av_valid_q;
  logic                 err_q;

  logic [PW-1:0]        avail_port;
  logic [NUM_PORTS-1:0] capture, avail_hit, underflow;

  assign avail_port = avail_id[TW-1:IW];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign capture[gi]    = req_valid[gi] & ~hold_valid_q[gi];
    assign avail_hit[gi]  = avail_valid & (avail_port == PW'(gi));
    assign underflow[gi]  = avail_hit[gi] & (outstanding_q[gi] == '0);
    assign port_ready[gi] = ~hold_valid_q[gi] & ~req_valid[gi] & (outstanding_q[gi] < CNT_MAX);
  end

  // A pulse arriving while the port's entry is still held is dropped, not merged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        hold_addr_q[i]   <= '0;
        hold_id_q[i]     <= '0;
        hold_off_q[i]    <= '0;
        outstanding_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (capture[i]) begin
          hold_valid_q[i] <= 1'b1;
          hold_addr_q[i]  <= req_addr[i*AW +: AW];
          hold_id_q[i]    <= req_id[i*IW +: IW];
          hold_off_q[i]   <= req_offset[i*OW +: OW];
        end else if (done_offer && (grant_q == PW'(i))) begin
          hold_valid_q[i] <= 1'b0;
        end
        if (capture[i] && !avail_hit[i]) begin
          if (outstanding_q[i] != '1)
            outstanding_q[i] <= outstanding_q[i] + CW'(1);
        end else if (!capture[i] && avail_hit[i] && (outstanding_q[i] != '0)) begin
          outstanding_q[i] <= outstanding_q[i] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand_sum >= NP_EXT)
        cand_sum = cand_sum - NP_EXT;
      cand = cand_sum[PW-1:0];
      if (!win_found && hold_valid_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load_offer = 1'b0;
    done_offer = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          load_offer = 1'b1;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (m_req_ready) begin
          done_offer = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_addr_q  <= '0;
      m_off_q   <= '0;
      m_id_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_offer) begin
        grant_q   <= win_idx;
        rr_ptr_q  <= (win_idx == LAST_PORT) ? '0 : win_idx + PW'(1);
        m_addr_q  <= hold_addr_q[win_idx];
        m_off_q   <= hold_off_q[win_idx];
        m_id_q    <= {win_idx, hold_id_q[win_idx]};
        m_valid_q <= 1'b1;
      end else if (done_offer) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      av_addr_q  <= '0;
      av_off_q   <= '0;
      av_id_q    <= '0;
      av_data_q  <= '0;
      av_valid_q <= '0;
      err_q      <= 1'b0;
    end else begin
      av_valid_q <= avail_hit;
      if (avail_valid) begin
        av_addr_q <= avail_addr;
        av_off_q  <= avail_offset;
        av_id_q   <= avail_id[IW-1:0];
        av_data_q <= avail_data;
      end
      err_q <= err_q | (|underflow);
    end
  end

  assign m_req_addr       = m_addr_q;
  assign m_req_offset     = m_off_q;
  assign m_req_id         = m_id_q;
  assign m_req_valid      = m_valid_q;
  assign out_avail_addr   = av_addr_q;
  assign out_avail_offset = av_off_q;
  assign out_avail_id     = av_id_q;
  assign out_avail_data   = av_data_q;
  assign out_avail_valid  = av_valid_q;
  assign err_underflow    = err_q;

`ifdef NOTIF_ARB_STATS_EN
  logic [31:0] stat_q [NUM_PORTS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        stat_q[i] <= '0;
    end else if (done_offer) begin
      stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
    assign stat_grants[gi*32 +: 32] = stat_q[gi];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_notification_arbiter.sv
// Scoreboard bench for notification_arbiter: expected grants and availability deliveries are
// queued at stimulus time and checked when the DUT presents them.
module tb_notification_arbiter;
  localparam int NP = 4;
  localparam int AW = 34;
  localparam int IW = 1;
  localparam int OW = 2;
  localparam int PW = 2;
  localparam int TW = 3;
  localparam int DW = 512;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*IW-1:0]  req_id;
  logic [NP*OW-1:0]  req_offset;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     port_ready;
  logic [AW-1:0]     m_req_addr;
  logic [OW-1:0]     m_req_offset;
  logic [TW-1:0]     m_req_id;
  logic              m_req_valid;
  logic              m_req_ready;
  logic [AW-1:0]     avail_addr;
  logic [OW-1:0]     avail_offset;
  logic [TW-1:0]     avail_id;
  logic [DW-1:0]     avail_data;
  logic              avail_valid;
  logic [AW-1:0]     out_avail_addr;
  logic [OW-1:0]     out_avail_offset;
  logic [IW-1:0]     out_avail_id;
  logic [DW-1:0]     out_avail_data;
  logic [NP-1:0]     out_avail_valid;
  logic              err_underflow;
  logic [NP*32-1:0]  stat_grants;

  always #5 clock = ~clock;

  notification_arbiter #(
    .NUM_PORTS(NP), .C_S_AXI_ID_WIDTH(IW), .CHANNEL_ADDR_WIDTH(AW),
    .BEATS(4), .C_BRAM_DATA_WIDTH(DW), .MAX_OUTSTANDING(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_addr(req_addr), .req_id(req_id), .req_offset(req_offset),
    .req_valid(req_valid), .port_ready(port_ready),
    .m_req_addr(m_req_addr), .m_req_offset(m_req_offset), .m_req_id(m_req_id),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .avail_addr(avail_addr), .avail_offset(avail_offset), .avail_id(avail_id),
    .avail_data(avail_data), .avail_valid(avail_valid),
    .out_avail_addr(out_avail_addr), .out_avail_offset(out_avail_offset),
    .out_avail_id(out_avail_id), .out_avail_data(out_avail_data),
    .out_avail_valid(out_avail_valid), .err_underflow(err_underflow),
    .stat_grants(stat_grants)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [OW-1:0] off;
    logic [TW-1:0] id;
  } gexp_t;

  typedef struct {
    logic [NP-1:0] vec;
    logic [AW-1:0] addr;
    logic [OW-1:0] off;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } aexp_t;

  gexp_t gq[$];
  aexp_t aq[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic fire();
    tick();
    req_valid = '0;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [IW-1:0] id,
                         input logic [OW-1:0] off, input bit push);
    gexp_t g;
    req_addr[p*AW +: AW]   = a;
    req_id[p*IW +: IW]     = id;
    req_offset[p*OW +: OW] = off;
    req_valid[p]           = 1'b1;
    if (push) begin
      g.addr = a;
      g.off  = off;
      g.id   = {PW'(p), id};
      gq.push_back(g);
    end
  endtask

  task automatic set_avail(input int p, input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [OW-1:0] off);
    aexp_t e;
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++)
      d[w*32 +: 32] = $urandom;
    avail_addr   = a;
    avail_offset = off;
    avail_id     = {PW'(p), id};
    avail_data   = d;
    avail_valid  = 1'b1;
    e.vec    = '0;
    e.vec[p] = 1'b1;
    e.addr   = a;
    e.off    = off;
    e.id     = id;
    e.data   = d;
    aq.push_back(e);
  endtask

  task automatic send_avail(input int p, input logic [AW-1:0] a, input logic [IW-1:0] id,
                            input logic [OW-1:0] off);
    set_avail(p, a, id, off);
    tick();
    avail_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    req_valid   = '0;
    avail_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  gexp_t g_mon;
  aexp_t a_mon;

  always @(negedge clock) begin
    if (reset === 1'b0 && m_req_valid === 1'b1 && m_req_ready === 1'b1) begin
      $display("grant id=0x%0h addr=0x%0h off=%0d", m_req_id, m_req_addr, m_req_offset);
      chk("grant_expected", 64'(gq.size() != 0), 64'd1);
      if (gq.size() != 0) begin
        g_mon = gq.pop_front();
        chk("m_req_id", 64'(m_req_id), 64'(g_mon.id));
        chk("m_req_addr", 64'(m_req_addr), 64'(g_mon.addr));
        chk("m_req_offset", 64'(m_req_offset), 64'(g_mon.off));
      end
    end
    if (reset === 1'b0 && out_avail_valid !== '0) begin
      $display("avail vec=0x%0h id=%0d addr=0x%0h", out_avail_valid, out_avail_id, out_avail_addr);
      chk("avail_expected", 64'(aq.size() != 0), 64'd1);
      if (aq.size() != 0) begin
        a_mon = aq.pop_front();
        chk("out_avail_valid", 64'(out_avail_valid), 64'(a_mon.vec));
        chk("out_avail_id", 64'(out_avail_id), 64'(a_mon.id));
        chk("out_avail_addr", 64'(out_avail_addr), 64'(a_mon.addr));
        chk("out_avail_offset", 64'(out_avail_offset), 64'(a_mon.off));
        chk("out_avail_data_lo", out_avail_data[63:0], a_mon.data[63:0]);
        chk("out_avail_data_hi", out_avail_data[DW-1:DW-64], a_mon.data[DW-1:DW-64]);
      end
    end
  end

  bit seen;

  initial begin
    reset        = 1'b1;
    req_addr     = '0;
    req_id       = '0;
    req_offset   = '0;
    req_valid    = '0;
    m_req_ready  = 1'b0;
    avail_addr   = '0;
    avail_offset = '0;
    avail_id     = '0;
    avail_data   = '0;
    avail_valid  = 1'b0;
    repeat (2) @(posedge clock);
    #2;

    chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("rst_m_req_id", 64'(m_req_id), 64'd0);
    chk("rst_m_req_addr", 64'(m_req_addr), 64'd0);
    chk("rst_out_avail_valid", 64'(out_avail_valid), 64'd0);
    chk("rst_out_avail_data", out_avail_data[63:0], 64'd0);
    chk("rst_err_underflow", 64'(err_underflow), 64'd0);
    chk("rst_port_ready", 64'(port_ready), 64'hF);
    chk("rst_stat_lo", stat_grants[63:0], 64'd0);
    reset = 1'b0;
    tick();

    // Single request, uncontended latency.
    m_req_ready = 1'b1;
    set_req(2, 34'h100, 1'b1, 2'd3, 1'b1);
    #1 chk("p2_ready_during_pulse", 64'(port_ready[2]), 64'd0);
    fire();
    chk("lat_c1_valid", 64'(m_req_valid), 64'd0);
    chk("lat_c1_p2_ready", 64'(port_ready[2]), 64'd0);
    tick();
    chk("lat_c2_valid", 64'(m_req_valid), 64'd1);
    chk("lat_c2_id", 64'(m_req_id), 64'h5);
    tick();
    chk("lat_c3_valid", 64'(m_req_valid), 64'd0);
    chk("lat_c3_p2_ready", 64'(port_ready[2]), 64'd1);

    // Round-robin ordering.
    apply_reset();
    m_req_ready = 1'b1;
    set_req(0, 34'h2000, 1'b0, 2'd0, 1'b1);
    set_req(1, 34'h2010, 1'b1, 2'd1, 1'b1);
    set_req(3, 34'h2030, 1'b1, 2'd3, 1'b1);
    fire();
    repeat (8) tick();
    chk("rr_burst1_drained", 64'(gq.size()), 64'd0);
    for (int p = 0; p < NP; p++)
      set_req(p, AW'(34'h3000 + p*16), IW'(p & 1), OW'(p), 1'b1);
    fire();
    repeat (10) tick();
    chk("rr_burst2_drained", 64'(gq.size()), 64'd0);
    set_req(2, 34'h3800, 1'b0, 2'd2, 1'b1);
    fire();
    repeat (4) tick();
    set_req(3, 34'h3930, 1'b0, 2'd1, 1'b1);
    set_req(0, 34'h3900, 1'b1, 2'd2, 1'b1);
    set_req(1, 34'h3910, 1'b0, 2'd3, 1'b1);
    fire();
    repeat (8) tick();
    chk("rr_burst3_drained", 64'(gq.size()), 64'd0);
`ifdef NOTIF_ARB_STATS_EN
    chk("stat_p0", 64'(stat_grants[31:0]), 64'd3);
    chk("stat_p1", 64'(stat_grants[63:32]), 64'd3);
    chk("stat_p2", 64'(stat_grants[95:64]), 64'd2);
    chk("stat_p3", 64'(stat_grants[127:96]), 64'd3);
`else
    chk("stat_lo_zero", stat_grants[63:0], 64'd0);
    chk("stat_hi_zero", stat_grants[127:64], 64'd0);
`endif

    // Back-pressure stall, with an illegal second pulse on the held port.
    apply_reset();
    m_req_ready = 1'b0;
    set_req(1, 34'h4440, 1'b1, 2'd2, 1'b1);
    fire();
    tick();
    chk("stall_valid_start", 64'(m_req_valid), 64'd1);
    set_req(1, 34'h5550, 1'b0, 2'd1, 1'b0);
    fire();
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 64'(m_req_valid), 64'd1);
      chk("stall_addr", 64'(m_req_addr), 64'h4440);
      chk("stall_id", 64'(m_req_id), 64'h3);
      chk("stall_p1_ready", 64'(port_ready[1]), 64'd0);
      tick();
    end
    m_req_ready = 1'b1;
    repeat (5) tick();
    chk("stall_drained", 64'(gq.size()), 64'd0);

    // Outstanding limit, availability routing, coincident capture and return.
    apply_reset();
    m_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(1, AW'(34'h6000 + k*64), IW'(k & 1), OW'(k & 3), 1'b1);
      fire();
      tick();
      tick();
    end
    chk("full_p1_ready", 64'(port_ready[1]), 64'd0);
    chk("full_p0_ready", 64'(port_ready[0]), 64'd1);
    send_avail(1, 34'h6000, 1'b0, 2'd2);
    chk("avail_route_vec", 64'(out_avail_valid), 64'h2);
    chk("avail_p1_ready", 64'(port_ready[1]), 64'd1);
    set_req(1, 34'h6400, 1'b1, 2'd1, 1'b1);
    set_avail(1, 34'h6040, 1'b1, 2'd0);
    fire();
    avail_valid = 1'b0;
    tick();
    tick();
    chk("coincide_p1_ready", 64'(port_ready[1]), 64'd1);
    set_req(1, 34'h6440, 1'b0, 2'd2, 1'b1);
    fire();
    tick();
    tick();
    chk("coincide_p1_full", 64'(port_ready[1]), 64'd0);

    // Underflow on an idle port.
    apply_reset();
    send_avail(0, 34'h7000, 1'b1, 2'd3);
    chk("uf_err", 64'(err_underflow), 64'd1);
    chk("uf_p0_ready", 64'(port_ready[0]), 64'd1);
    for (int k = 0; k < 7; k++) begin
      set_req(0, AW'(34'h7100 + k*64), 1'b0, 2'd0, 1'b1);
      fire();
      tick();
      tick();
    end
    chk("uf_p0_ready_after7", 64'(port_ready[0]), 64'd1);
    set_req(0, 34'h7800, 1'b1, 2'd1, 1'b1);
    fire();
    tick();
    tick();
    chk("uf_p0_full_after8", 64'(port_ready[0]), 64'd0);
    chk("uf_err_sticky", 64'(err_underflow), 64'd1);
    apply_reset();
    chk("uf_err_cleared", 64'(err_underflow), 64'd0);

    // Reset while an offer is pending.
    m_req_ready = 1'b0;
    set_req(0, 34'h8000, 1'b0, 2'd0, 1'b0);
    set_req(2, 34'h8020, 1'b1, 2'd2, 1'b0);
    fire();
    tick();
    chk("rst_offer_valid", 64'(m_req_valid), 64'd1);
    reset = 1'b1;
    #1 chk("rst_async_valid", 64'(m_req_valid), 64'd0);
    tick();
    reset = 1'b0;
    #1 chk("rst_release_ready", 64'(port_ready), 64'hF);
    m_req_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (m_req_valid === 1'b1)
        seen = 1'b1;
    end
    chk("rst_no_replay", 64'(seen), 64'd0);

    chk("end_grant_queue", 64'(gq.size()), 64'd0);
    chk("end_avail_queue", 64'(aq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
